// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine phase controller and its actuator driver.
// Phase codes, water-select bit positions, driver FSM states and the actuator bundle.
package wm_pkg;

    localparam logic [2:0] PH_OFF           = 3'd0;
    localparam logic [2:0] PH_IDLE          = 3'd1;
    localparam logic [2:0] PH_WASH_FILL     = 3'd2;
    localparam logic [2:0] PH_WASH_AGITATE  = 3'd3;
    localparam logic [2:0] PH_WASH_SPIN     = 3'd4;
    localparam logic [2:0] PH_RINSE_FILL    = 3'd5;
    localparam logic [2:0] PH_RINSE_AGITATE = 3'd6;
    localparam logic [2:0] PH_RINSE_SPIN    = 3'd7;

    localparam int W_HOT  = 1;
    localparam int W_COLD = 0;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Wash and rinse share the same actuator behaviour, so phases collapse to a kind.
    typedef enum logic [1:0] {
        K_NONE = 2'd0,
        K_FILL = 2'd1,
        K_AGIT = 2'd2,
        K_SPIN = 2'd3
    } kind_t;

    typedef struct packed {
        logic hot;
        logic cold;
        logic fwd;
        logic rev;
        logic spin;
        logic drain;
    } act_t;

    localparam act_t ACT_OFF = '0;

    function automatic kind_t phase_kind(input logic [2:0] ph);
        case (ph)
            PH_WASH_FILL, PH_RINSE_FILL:       return K_FILL;
            PH_WASH_AGITATE, PH_RINSE_AGITATE: return K_AGIT;
            PH_WASH_SPIN, PH_RINSE_SPIN:       return K_SPIN;
            default:                           return K_NONE;
        endcase
    endfunction

    function automatic act_t act_map(input kind_t k, input logic [1:0] w,
                                     input logic agit_fwd, input logic agit_rev);
        act_t a;
        a = ACT_OFF;
        case (k)
            K_FILL: begin
                a.hot  = w[W_HOT];
                a.cold = w[W_COLD];
            end
            K_AGIT: begin
                a.fwd = agit_fwd;
                a.rev = agit_rev;
            end
            K_SPIN: begin
                a.drain = 1'b1;
                a.fwd   = 1'b1;
                a.spin  = 1'b1;
            end
            default: ;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/wm_agitate_gen.sv
// Agitate stroke generator: forward stroke, dead time, reverse stroke, dead time, repeat.
// fwd/rev describe the position the counter takes on the coming edge, so the parent can register them.
module wm_agitate_gen #(
    parameter logic [7:0] HALF = 8'd20,
    parameter logic [7:0] DEAD = 8'd2
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic en,
    input  logic freeze,
    output logic fwd,
    output logic rev
);

    localparam int PW = 10;
    localparam logic [PW-1:0] B_FWD  = {2'b00, HALF};
    localparam logic [PW-1:0] B_OFF1 = B_FWD + {2'b00, DEAD};
    localparam logic [PW-1:0] B_REV  = B_OFF1 + {2'b00, HALF};
    localparam logic [PW-1:0] B_LAST = B_REV + {2'b00, DEAD} - 10'd1;

    logic [PW-1:0] pos_reg;
    logic [PW-1:0] pos_next;

    always_comb begin
        pos_next = pos_reg;
        if (clear) begin
            pos_next = '0;
        end else if (en && !freeze) begin
            pos_next = (pos_reg >= B_LAST) ? '0 : pos_reg + 10'd1;
        end
        fwd = (pos_next < B_FWD);
        rev = (pos_next >= B_OFF1) && (pos_next < B_REV);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            pos_reg <= '0;
        end else begin
            pos_reg <= pos_next;
        end
    end

endmodule

// File: rtl/wm_actuator_driver.sv
// Actuator driver: times each controller phase, drives valves/motor/pump/lock and
// returns a one-cycle phase_done strobe. Opening the door pauses the phase in place.
module wm_actuator_driver
    import wm_pkg::*;
#(
    parameter int             TW        = 16,
    parameter logic [TW-1:0]  FILL_CYC  = 16'd200,
    parameter logic [TW-1:0]  AGIT_CYC  = 16'd600,
    parameter logic [TW-1:0]  SPIN_CYC  = 16'd300,
    parameter logic [7:0]     AGIT_HALF = 8'd20,
    parameter logic [7:0]     DEAD      = 8'd2
) (
    input  logic          clkorig,
    input  logic          reset,
    input  logic [2:0]    phase,
    input  logic [1:0]    water,
    input  logic          door,
    output logic          hot_valve,
    output logic          cold_valve,
    output logic          motor_fwd,
    output logic          motor_rev,
    output logic          spin_hi,
    output logic          drain_pump,
    output logic          door_lock,
    output logic          phase_done,
    output logic [TW-1:0] time_left
);

    state_t     state_reg;
    logic [2:0] prev_phase_reg;
    act_t       act_reg;

    kind_t new_kind;
    kind_t cur_kind;
    logic  phase_changed;
    logic  agit_fwd;
    logic  agit_rev;

    assign new_kind      = phase_kind(phase);
    assign cur_kind      = phase_kind(prev_phase_reg);
    assign phase_changed = (phase != prev_phase_reg);

    function automatic logic [TW-1:0] dur_of(input kind_t k);
        case (k)
            K_FILL:  return FILL_CYC;
            K_AGIT:  return AGIT_CYC;
            K_SPIN:  return SPIN_CYC;
            default: return '0;
        endcase
    endfunction

    // The stroke position only moves while actually running, so a pause resumes mid-stroke.
    wm_agitate_gen #(
        .HALF (AGIT_HALF),
        .DEAD (DEAD)
    ) u_agit (
        .clk    (clkorig),
        .srst   (reset),
        .clear  (phase_changed),
        .en     (cur_kind == K_AGIT),
        .freeze (state_reg != S_RUN),
        .fwd    (agit_fwd),
        .rev    (agit_rev)
    );

    always_ff @(posedge clkorig) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            prev_phase_reg <= PH_OFF;
            act_reg        <= ACT_OFF;
            door_lock      <= 1'b0;
            phase_done     <= 1'b0;
            time_left      <= '0;
        end else begin
            prev_phase_reg <= phase;
            phase_done     <= 1'b0;
            act_reg        <= ACT_OFF;
            door_lock      <= 1'b0;

            if (phase_changed) begin
                if (new_kind == K_NONE) begin
                    state_reg <= S_IDLE;
                    time_left <= '0;
                end else begin
                    time_left <= dur_of(new_kind);
                    if (door) begin
                        state_reg <= S_PAUSE;
                    end else begin
                        state_reg <= S_RUN;
                        act_reg   <= act_map(new_kind, water, agit_fwd, agit_rev);
                        door_lock <= 1'b1;
                    end
                end
            end else begin
                case (state_reg)
                    S_RUN: begin
                        // The cycle just spent running still counts when the door opens.
                        if (door) begin
                            state_reg <= S_PAUSE;
                            time_left <= (time_left == '0) ? '0 : time_left - 1'b1;
                        end else if (time_left <= {{(TW-1){1'b0}}, 1'b1}) begin
                            state_reg  <= S_DONE;
                            phase_done <= 1'b1;
                            time_left  <= '0;
                        end else begin
                            time_left <= time_left - 1'b1;
                            act_reg   <= act_map(cur_kind, water, agit_fwd, agit_rev);
                            door_lock <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (!door) begin
                            if (time_left == '0) begin
                                state_reg  <= S_DONE;
                                phase_done <= 1'b1;
                            end else begin
                                state_reg <= S_RUN;
                                act_reg   <= act_map(cur_kind, water, agit_fwd, agit_rev);
                                door_lock <= 1'b1;
                            end
                        end
                    end
                    S_DONE: ;
                    S_IDLE: ;
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign hot_valve  = act_reg.hot;
    assign cold_valve = act_reg.cold;
    assign motor_fwd  = act_reg.fwd;
    assign motor_rev  = act_reg.rev;
    assign spin_hi    = act_reg.spin;
    assign drain_pump = act_reg.drain;

    always_ff @(posedge clkorig) begin
        if (!reset) begin
            assert (FILL_CYC != '0 && AGIT_CYC != '0 && SPIN_CYC != '0 &&
                    AGIT_HALF != '0 && DEAD != '0)
                else $error("wm_actuator_driver: zero duration parameter");
            assert (!(act_reg.fwd && act_reg.rev))
                else $error("wm_actuator_driver: motor forward and reverse both on");
        end
    end

endmodule

// File: tb/tb_wm_actuator_driver.sv
// Directed bench for wm_actuator_driver with short phase durations.
// Outputs are sampled 1 time unit after each rising edge; inputs change at the same point.
module tb_wm_actuator_driver;

    logic        clkorig = 1'b0;
    logic        reset;
    logic [2:0]  phase;
    logic [1:0]  water;
    logic        door;
    logic        hot_valve, cold_valve, motor_fwd, motor_rev, spin_hi, drain_pump;
    logic        door_lock, phase_done;
    logic [15:0] time_left;

    int tests = 0;
    int fails = 0;

    localparam logic [7:0] HOT   = 8'h80;
    localparam logic [7:0] COLD  = 8'h40;
    localparam logic [7:0] FWD   = 8'h20;
    localparam logic [7:0] REV   = 8'h10;
    localparam logic [7:0] SPIN  = 8'h08;
    localparam logic [7:0] DRAIN = 8'h04;
    localparam logic [7:0] LOCK  = 8'h02;
    localparam logic [7:0] DONE  = 8'h01;
    localparam logic [7:0] NONE  = 8'h00;

    logic [7:0] obs;
    assign obs = {hot_valve, cold_valve, motor_fwd, motor_rev, spin_hi, drain_pump,
                  door_lock, phase_done};

    wm_actuator_driver #(
        .TW        (16),
        .FILL_CYC  (16'd8),
        .AGIT_CYC  (16'd12),
        .SPIN_CYC  (16'd6),
        .AGIT_HALF (8'd4),
        .DEAD      (8'd1)
    ) dut (
        .clkorig    (clkorig),
        .reset      (reset),
        .phase      (phase),
        .water      (water),
        .door       (door),
        .hot_valve  (hot_valve),
        .cold_valve (cold_valve),
        .motor_fwd  (motor_fwd),
        .motor_rev  (motor_rev),
        .spin_hi    (spin_hi),
        .drain_pump (drain_pump),
        .door_lock  (door_lock),
        .phase_done (phase_done),
        .time_left  (time_left)
    );

    always #5 clkorig = ~clkorig;

    task automatic step();
        @(posedge clkorig);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] eb, input logic [15:0] et);
        tests++;
        assert (obs === eb && time_left === et) else begin
            fails++;
            $error("FAIL %s: outputs=%b time_left=%0d, required outputs=%b time_left=%0d",
                   tag, obs, time_left, eb, et);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: got %0d, required %0d", tag, got, want);
        end
    endtask

    function automatic logic [7:0] first_cycle(input int p);
        case (p)
            2, 5:    return HOT | COLD | LOCK;
            3, 6:    return FWD | LOCK;
            default: return DRAIN | FWD | SPIN | LOCK;
        endcase
    endfunction

    function automatic int dur(input int p);
        case (p)
            2, 5:    return 8;
            3, 6:    return 12;
            default: return 6;
        endcase
    endfunction

    initial begin
        logic [7:0] eb;
        int n;
        int pulses;
        int bad;

        // Reset state
        reset = 1'b1; phase = 3'd0; water = 2'b00; door = 1'b0;
        step(); step();
        chk("reset", NONE, 16'd0);
        reset = 1'b0;

        // Hot fill: 8 active cycles, one done pulse, then valves closed
        phase = 3'd1;
        step();
        chk("idle", NONE, 16'd0);
        phase = 3'd2; water = 2'b10;
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fill_c%0d", k + 1), HOT | LOCK, 16'(8 - k));
            step();
        end
        chk("fill_done", DONE, 16'd0);
        step();
        chk("fill_after", NONE, 16'd0);

        // Agitate stroke pattern
        phase = 3'd3; water = 2'b00;
        step();
        for (int c = 1; c <= 12; c++) begin
            eb = LOCK;
            if (c <= 4 || c >= 11) eb = eb | FWD;
            if (c >= 6 && c <= 9)  eb = eb | REV;
            chk($sformatf("agit_c%0d", c), eb, 16'(13 - c));
            step();
        end
        chk("agit_done", DONE, 16'd0);

        // Reset mid-agitate, then reload with phase held at 3
        phase = 3'd1;
        step();
        phase = 3'd3;
        step(); step(); step();
        reset = 1'b1;
        step();
        chk("reset_mid_agit", NONE, 16'd0);
        reset = 1'b0;
        step();
        chk("agit_reload_c1", FWD | LOCK, 16'd12);
        step();
        chk("agit_reload_c2", FWD | LOCK, 16'd11);

        // Spin with a 5-cycle door opening after 3 cycles
        phase = 3'd4;
        step();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("spin_c%0d", k + 1), DRAIN | FWD | SPIN | LOCK, 16'(6 - k));
            if (k < 2) step();
        end
        door = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("spin_pause%0d", k + 1), NONE, 16'd3);
        end
        door = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("spin_resume%0d", k + 1), DRAIN | FWD | SPIN | LOCK, 16'(3 - k));
        end
        step();
        chk("spin_done", DONE, 16'd0);
        step();
        chk("spin_after", NONE, 16'd0);

        // Fill aborted at time_left=4 by a change to agitate
        phase = 3'd5; water = 2'b01;
        step();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rfill_c%0d", k + 1), COLD | LOCK, 16'(8 - k));
            step();
        end
        chk("rfill_at4", COLD | LOCK, 16'd4);
        phase = 3'd6;
        step();
        chk("ragit_start", FWD | LOCK, 16'd12);
        step();
        chk("ragit_c2", FWD | LOCK, 16'd11);

        // Full sequence 2..7 advanced by phase_done
        phase = 3'd1; water = 2'b11;
        step();
        chk("seq_idle", NONE, 16'd0);
        pulses = 0;
        for (int p = 2; p <= 7; p++) begin
            phase = 3'(p);
            step();
            chk($sformatf("seq_p%0d_first", p), first_cycle(p), 16'(dur(p)));
            n = 0;
            bad = 0;
            while (phase_done !== 1'b1 && n < 60) begin
                if ((motor_fwd & motor_rev) ||
                    ((hot_valve | cold_valve) & (motor_fwd | motor_rev | drain_pump)))
                    bad++;
                step();
                n++;
            end
            chk_int($sformatf("seq_p%0d_invariants", p), bad, 0);
            chk_int($sformatf("seq_p%0d_cycles", p), n, dur(p));
            if (phase_done === 1'b1) pulses++;
        end
        step();
        chk("seq_end", NONE, 16'd0);
        chk_int("seq_pulses", pulses, 6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
